alu_share_ctrl: RTL and testbench
=================================

// Module: alu_share_ctrl
// PURPOSE
//  Controller that shares one combinational 32-bit ALU (ADD/SUB/SLL/SLT/XOR/SRL/SRA/OR/AND) between two requesters.
//  Arbitrates round-robin, drives the ALU from registered operands and returns one tagged result per request.
//  Adds a multi-cycle MUL (low 32 bits) built from the ALU adder.
//  Sits between issue logic (req0/req1) and the ALU instance.
// PARAMETERS
//  W       32  data width of operands/results
//  SHW     5   shift-amount width (log2 W)
//  MUL_EN  1   1: op 4'b0011 runs iterative MUL; 0: 4'b0011 is illegal
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous reset, active low
//  reqN_valid in   1    N=0,1: request present
//  reqN_ready out  1    N=0,1: request accepted this cycle when valid&ready
//  reqN_op    in   4    N=0,1: ALUop code
//  reqN_a     in   W    N=0,1: operand A
//  reqN_b     in   W    N=0,1: operand B
//  reqN_sh    in   SHW  N=0,1: shift amount
//  rsp_valid  out  1    result present
//  rsp_ready  in   1    consumer accepts result
//  rsp_id     out  1    requester the result belongs to
//  rsp_y      out  W    result (Y, or {0,less} for SLT)
//  rsp_ovf    out  1    signed overflow (ADD/SUB only, else 0)
//  rsp_zero   out  1    rsp_y == 0
//  rsp_err    out  1    illegal op; rsp_y = 0
//  alu_a/alu_b out W ; alu_op out 4 ; alu_sh out SHW : drive the shared ALU
//  alu_y in W ; alu_less in W ; alu_ovf in 1 : ALU results, combinational
// BEHAVIOUR
//  Op codes: ADD 0000, SUB 1000, SLL 0001/1001, SLT 0010/1010, XOR 0100/1100, SRL 0101, SRA 1101, OR 0110/1110, AND 0111/1111.
//  Op codes: MUL 0011 (MUL_EN=1).
//  Illegal: 1011, and 0011 when MUL_EN=0.
//  FSM states: IDLE, EXEC, MUL, RESP.
//  Reset: state=IDLE, rr pointer favours req0, all outputs 0, alu_* driven 0.
//  IDLE:
//   - reqN_ready=1 only for the arbiter winner; the other requester's ready=0.
//   - Arbitration is round-robin: if both valid, grant the requester not granted last time.
//   - Handshake captures op/a/b/sh/id into registers.
//   - Next state is EXEC, MUL (op 0011, MUL_EN=1) or RESP with err=1 (illegal op).
//  EXEC (1 cycle):
//   - alu_* driven from registers; capture y = (SLT ? alu_less : alu_y).
//   - Capture ovf = alu_ovf for ADD/SUB, else 0.
//   - Next state is RESP.
//  MUL (exactly W cycles):
//   - Registers: acc=0, mcand=a, mplier=b.
//   - Each cycle: alu_a=acc, alu_b=mcand, alu_op=ADD.
//   - If mplier[0]=1, acc<=alu_y.
//   - Then mcand<<=1 and mplier>>=1 in local flops.
//   - After W cycles y=acc, ovf=0; next state is RESP.
//  RESP:
//   - rsp_valid=1 with stable fields until rsp_ready.
//   - On rsp_valid&rsp_ready, next state is IDLE; no accept in the same cycle.
//  Latency, accept to rsp_valid: 2 cycles for single-cycle ops, W+1 cycles for MUL, 1 cycle for illegal ops.
//  rsp_zero is computed from the registered y (not from the ALU zero flag).
//  reqN_valid asserted while not ready: held, and has no effect.
//  Long rsp_ready low: block stalls in RESP; both readys stay 0.
//  Reset mid-op: in-flight request is dropped, no response.
//  alu_* outside EXEC/MUL: held at 0.
// STRUCTURE
//  alu_defs.vh: op-code and state localparams, shared with the ALU and issue logic.
//  Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], advance, gnt[1:0]); pointer updates only on accepted grant.
//  Remaining FSM, operand regs and MUL shift regs live in alu_share_ctrl.
// TESTING (bench instantiates this block with the real ALU)
//  1. req0 ADD a=7FFFFFFF b=1 -> rsp 2 cycles later: id=0, y=80000000, ovf=1, zero=0.
//  2. req1 SUB a=5 b=5 -> y=0, zero=1, ovf=0. Then req1 SLT a=FFFFFFFF b=1 -> y=1.
//  3. req0+req1 valid together, 4 ops each -> grants alternate 0,1,0,1...; after reset, first grant goes to 0.
//  4. MUL a=0000FFFF b=00010001 -> y=FFFFFFFF after W+1 cycles. MUL a=FFFFFFFF b=FFFFFFFF -> y=00000001.
//  5. Hold rsp_ready=0 for 10 cycles -> rsp fields stable, both readys=0. op 1011 -> err=1, y=0, rsp 1 cycle after accept.
//  6. Assert rst_n=0 at MUL cycle 12 -> outputs 0, state IDLE, no response; next request completes normally.

Source files
------------

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: op codes, FSM states,
// and op-decode helpers used by the controller.
package alu_share_ctrl_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b1000;
   localparam logic [3:0] OP_MUL = 4'b0011;
   localparam logic [3:0] OP_ILL = 4'b1011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   // SLT is encoded as x010; its result comes from the ALU less output.
   function automatic logic is_slt(input logic [3:0] op);
      return op[2:0] == 3'b010;
   endfunction

   // Only ADD (0000) and SUB (1000) report signed overflow.
   function automatic logic is_addsub(input logic [3:0] op);
      return op[2:0] == 3'b000;
   endfunction

   // 1011 is never legal; 0011 is legal only when the multiplier is built in.
   function automatic logic is_legal(input logic [3:0] op, input logic mul_en);
      return (op != OP_ILL) && !((op == OP_MUL) && !mul_en);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. When both request, the one not granted last
// time wins; the pointer only moves when the grant is actually accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   logic ptr;  // 1: requester 1 is favoured on a tie

   // Grant the favoured side on a tie, otherwise whoever is asking.
   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
   end

   // After an accepted grant, favour the other requester next time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ptr <= 1'b0;
      else if (advance) ptr <= gnt[0];
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Requests are
// arbitrated round-robin, executed from registered operands (single cycle,
// or W iterations of shift-and-add for MUL) and answered with a tagged
// response held until the consumer takes it.
module alu_share_ctrl
   import alu_share_ctrl_pkg::*;
#(
   parameter int W      = 32,
   parameter int SHW    = 5,
   parameter int MUL_EN = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [3:0]     req0_op,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [SHW-1:0] req0_sh,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [3:0]     req1_op,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [SHW-1:0] req1_sh,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic           rsp_id,
   output logic [W-1:0]   rsp_y,
   output logic           rsp_ovf,
   output logic           rsp_zero,
   output logic           rsp_err,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [3:0]     alu_op,
   output logic [SHW-1:0] alu_sh,
   input  logic [W-1:0]   alu_y,
   input  logic [W-1:0]   alu_less,
   input  logic           alu_ovf
);

   localparam int CW = $clog2(W);

   state_t         state, state_nxt;
   logic [1:0]     gnt;
   logic           sel, accept, in_legal;
   logic [3:0]     in_op;
   logic [W-1:0]   in_a, in_b;
   logic [SHW-1:0] in_sh;

   // Operand registers; during MUL opa_r/opb_r double as multiplicand and
   // multiplier shift registers, so no extra flops are needed for them.
   logic [3:0]     op_r;
   logic [W-1:0]   opa_r, opb_r, acc_r;
   logic [SHW-1:0] sh_r;
   logic [CW-1:0]  cnt_r;
   logic           mul_last;
   logic [W-1:0]   mul_sum;

   rr_arb2 u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({req1_valid, req0_valid}),
      .advance (accept),
      .gnt     (gnt)
   );

   assign sel      = gnt[1];
   assign accept   = (state == ST_IDLE) && (gnt != 2'b00);
   assign in_op    = sel ? req1_op : req0_op;
   assign in_a     = sel ? req1_a  : req0_a;
   assign in_b     = sel ? req1_b  : req0_b;
   assign in_sh    = sel ? req1_sh : req0_sh;
   assign in_legal = is_legal(in_op, MUL_EN != 0);

   assign mul_last = cnt_r == CW'(W - 1);
   assign mul_sum  = opb_r[0] ? alu_y : acc_r;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) begin
            if (!in_legal)          state_nxt = ST_RESP;
            else if (in_op == OP_MUL) state_nxt = ST_MUL;
            else                    state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_MUL:  if (mul_last) state_nxt = ST_RESP;
         ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: handshakes per state, ALU driven only while it is in use.
   always_comb begin
      req0_ready = (state == ST_IDLE) && gnt[0];
      req1_ready = (state == ST_IDLE) && gnt[1];
      rsp_valid  = (state == ST_RESP);
      alu_a      = '0;
      alu_b      = '0;
      alu_op     = '0;
      alu_sh     = '0;
      case (state)
         ST_EXEC: begin
            alu_a  = opa_r;
            alu_b  = opb_r;
            alu_op = op_r;
            alu_sh = sh_r;
         end
         ST_MUL: begin
            alu_a  = acc_r;
            alu_b  = opa_r;
            alu_op = OP_ADD;
         end
         default: ;
      endcase
   end

   // Zero flag follows the held result, only while a response is offered.
   assign rsp_zero = rsp_valid && (rsp_y == '0);

   // Operand capture, execute/multiply datapath and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r    <= '0;
         opa_r   <= '0;
         opb_r   <= '0;
         sh_r    <= '0;
         acc_r   <= '0;
         cnt_r   <= '0;
         rsp_id  <= 1'b0;
         rsp_y   <= '0;
         rsp_ovf <= 1'b0;
         rsp_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_r    <= in_op;
               opa_r   <= in_a;
               opb_r   <= in_b;
               sh_r    <= in_sh;
               acc_r   <= '0;
               cnt_r   <= '0;
               rsp_id  <= sel;
               rsp_y   <= '0;
               rsp_ovf <= 1'b0;
               rsp_err <= !in_legal;
            end
            ST_EXEC: begin
               rsp_y   <= is_slt(op_r) ? alu_less : alu_y;
               rsp_ovf <= is_addsub(op_r) && alu_ovf;
            end
            ST_MUL: begin
               acc_r <= mul_sum;
               opa_r <= opa_r << 1;
               opb_r <= opb_r >> 1;
               cnt_r <= cnt_r + CW'(1);
               if (mul_last) rsp_y <= mul_sum;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a behavioural ALU on the alu_* port, a directed
// vector table, hand-written arbitration/stall/reset sequences and random
// traffic checked against a reference computed from the op definitions.
module tb_alu_share_ctrl;

   localparam int W = 32;
   localparam int SHW = 5;
   localparam int MUL_EN = 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [1:0]     req_valid = 2'b00;
   logic [3:0]     r_op [2];
   logic [W-1:0]   r_a  [2];
   logic [W-1:0]   r_b  [2];
   logic [SHW-1:0] r_sh [2];
   logic           req0_ready, req1_ready;
   logic           rsp_valid, rsp_id, rsp_ovf, rsp_zero, rsp_err;
   logic           rsp_ready = 1'b0;
   logic [W-1:0]   rsp_y;
   logic [W-1:0]   alu_a, alu_b, alu_y, alu_less;
   logic [3:0]     alu_op;
   logic [SHW-1:0] alu_sh;
   logic           alu_ovf;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_share_ctrl #(.W(W), .SHW(SHW), .MUL_EN(MUL_EN)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_op(r_op[0]),
      .req0_a(r_a[0]), .req0_b(r_b[0]), .req0_sh(r_sh[0]),
      .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_op(r_op[1]),
      .req1_a(r_a[1]), .req1_b(r_b[1]), .req1_sh(r_sh[1]),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sh(alu_sh),
      .alu_y(alu_y), .alu_less(alu_less), .alu_ovf(alu_ovf)
   );

   // Stand-in for the shared ALU; its adder overflow flag is raw for every op.
   always_comb begin
      logic [W-1:0] sum;
      sum      = alu_op[3] ? alu_a - alu_b : alu_a + alu_b;
      alu_ovf  = alu_op[3] ? (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1])
                           : (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
      alu_less = {{(W-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      alu_y    = '0;
      case (alu_op)
         4'b0000, 4'b1000, 4'b0010, 4'b1010: alu_y = sum;
         4'b0001, 4'b1001: alu_y = alu_a << alu_sh;
         4'b0100, 4'b1100: alu_y = alu_a ^ alu_b;
         4'b0101:          alu_y = alu_a >> alu_sh;
         4'b1101:          alu_y = W'($signed(alu_a) >>> alu_sh);
         4'b0110, 4'b1110: alu_y = alu_a | alu_b;
         4'b0111, 4'b1111: alu_y = alu_a & alu_b;
         default:          alu_y = '0;
      endcase
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic rdy(input int id);
      return (id != 0) ? req1_ready : req0_ready;
   endfunction

   // Expected response from the op definitions, using wide signed arithmetic.
   function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, b,
                                     input logic [4:0] sh, output logic [31:0] y,
                                     output logic ovf, output logic err, output int lat);
      longint s, hi, lo;
      hi = (longint'(1) <<< 31) - 1;
      lo = -(longint'(1) <<< 31);
      y = '0; ovf = 1'b0; err = 1'b0; lat = 2; s = 0;
      case (op)
         4'b0000: s = longint'($signed(a)) + longint'($signed(b));
         4'b1000: s = longint'($signed(a)) - longint'($signed(b));
         default: ;
      endcase
      case (op)
         4'b0000, 4'b1000: begin y = 32'(s); ovf = (s > hi) || (s < lo); end
         4'b0001, 4'b1001: y = a << sh;
         4'b0010, 4'b1010: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0100, 4'b1100: y = a ^ b;
         4'b0101:          y = a >> sh;
         4'b1101:          y = 32'($signed(a) >>> sh);
         4'b0110, 4'b1110: y = a | b;
         4'b0111, 4'b1111: y = a & b;
         4'b0011: if (MUL_EN != 0) begin y = a * b; lat = W + 1; end
                  else begin err = 1'b1; lat = 1; end
         default: begin err = 1'b1; lat = 1; end
      endcase
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
   endtask

   // One complete request/response with latency and field checks.
   task automatic run_txn(input string tag, input int id, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] ey, input logic eovf, input logic eerr,
                          input int elat);
      int waitc, lat;
      @(negedge clk);
      r_op[id] = op; r_a[id] = a; r_b[id] = b; r_sh[id] = sh;
      req_valid[id] = 1'b1;
      #1; waitc = 0;
      while (!rdy(id) && waitc < 50) begin @(negedge clk); #1; waitc++; end
      chk({tag, " ready"}, 64'(rdy(id)), 64'd1);
      if (!rdy(id)) begin req_valid[id] = 1'b0; return; end
      @(posedge clk); #1;
      req_valid[id] = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk({tag, " latency"}, 64'(lat), 64'(elat));
      chk({tag, " id"}, 64'(rsp_id), 64'(id));
      chk({tag, " y"}, 64'(rsp_y), 64'(ey));
      chk({tag, " ovf"}, 64'(rsp_ovf), 64'(eovf));
      chk({tag, " err"}, 64'(rsp_err), 64'(eerr));
      chk({tag, " zero"}, 64'(rsp_zero), 64'(ey == 32'd0));
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({tag, " released"}, 64'(rsp_valid), 64'd0);
   endtask

   typedef struct {
      int         id;
      logic [3:0] op;
      logic [31:0] a, b;
      logic [4:0] sh;
      logic [31:0] y;
      logic       ovf, err;
      int         lat;
   } vec_t;

   initial begin
      vec_t vecs[$];
      logic [31:0] ey;
      logic eovf, eerr;
      int elat, waitc, g, lat;
      int cnt [2];
      logic [31:0] cap_y;
      logic cap_id, cap_err, stable, rdy_seen, seen;

      for (int i = 0; i < 2; i++) begin
         r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; r_sh[i] = '0;
      end

      vecs.push_back('{0, 4'b0000, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b1, 1'b0, 2});
      vecs.push_back('{1, 4'b1000, 32'h5,        32'h5,        5'd0,  32'h0,        1'b0, 1'b0, 2});
      vecs.push_back('{1, 4'b0010, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0, 2});
      vecs.push_back('{0, 4'b0011, 32'h0000FFFF, 32'h00010001, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, W+1});
      vecs.push_back('{1, 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h00000001, 1'b0, 1'b0, W+1});
      vecs.push_back('{0, 4'b1011, 32'h12345678, 32'h9,        5'd3,  32'h0,        1'b0, 1'b1, 1});
      vecs.push_back('{1, 4'b1101, 32'h80000000, 32'h0,        5'd4,  32'hF8000000, 1'b0, 1'b0, 2});
      vecs.push_back('{0, 4'b0101, 32'h80000000, 32'h0,        5'd4,  32'h08000000, 1'b0, 1'b0, 2});
      vecs.push_back('{1, 4'b1001, 32'h1,        32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0, 2});
      vecs.push_back('{0, 4'b1000, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b1, 1'b0, 2});
      vecs.push_back('{0, 4'b1010, 32'h1,        32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 1'b0, 2});
      vecs.push_back('{1, 4'b1100, 32'hF0F0F0F0, 32'hFFFF0000, 5'd0,  32'h0F0FF0F0, 1'b0, 1'b0, 2});
      vecs.push_back('{0, 4'b0110, 32'h00F0000F, 32'h0F000F00, 5'd0,  32'h0FF00F0F, 1'b0, 1'b0, 2});
      vecs.push_back('{1, 4'b1111, 32'hFF00FF00, 32'h0FF00FF0, 5'd0,  32'h0F000F00, 1'b0, 1'b0, 2});
      vecs.push_back('{0, 4'b0000, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b0, 1'b0, 2});

      // Reset state
      do_reset();
      #1;
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset readys", 64'({req1_ready, req0_ready}), 64'd0);
      chk("reset alu_a", 64'(alu_a), 64'd0);
      chk("reset alu_b", 64'(alu_b), 64'd0);
      chk("reset alu_op_sh", 64'({alu_op, alu_sh}), 64'd0);
      chk("reset rsp_fields", 64'({rsp_y, rsp_id, rsp_ovf, rsp_zero, rsp_err}), 64'd0);

      // Round-robin with both requesters always asking, first grant to 0
      cnt[0] = 0; cnt[1] = 0;
      for (int i = 0; i < 2; i++) begin
         r_op[i] = 4'b0000; r_a[i] = 32'(i * 100); r_b[i] = 32'd1;
      end
      @(negedge clk) req_valid = 2'b11;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1; waitc = 0;
         while (!(req0_ready || req1_ready) && waitc < 50) begin @(negedge clk); #1; waitc++; end
         chk("rr onehot", 64'(req0_ready && req1_ready), 64'd0);
         g = req1_ready ? 1 : 0;
         chk("rr grant", 64'(g), 64'(i % 2));
         @(posedge clk); #1;
         cnt[g]++;
         if (cnt[g] == 4) req_valid[g] = 1'b0;
         else r_a[g] = r_a[g] + 32'd1;
         lat = 1;
         while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
         chk("rr rsp_id", 64'(rsp_id), 64'(g));
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      end
      req_valid = 2'b00;

      // Directed vector table
      foreach (vecs[i])
         run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].sh, vecs[i].y, vecs[i].ovf, vecs[i].err, vecs[i].lat);

      // Long consumer stall: response held, nobody accepted meanwhile
      @(negedge clk);
      r_op[0] = 4'b0000; r_a[0] = 32'd3; r_b[0] = 32'd4; req_valid[0] = 1'b1;
      #1; waitc = 0;
      while (!req0_ready && waitc < 50) begin @(negedge clk); #1; waitc++; end
      @(posedge clk); #1;
      r_a[0] = 32'd9; r_op[1] = 4'b0000; req_valid = 2'b11;
      lat = 1;
      while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("stall y", 64'(rsp_y), 64'd7);
      cap_y = rsp_y; cap_id = rsp_id; cap_err = rsp_err;
      stable = 1'b1; rdy_seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         stable &= rsp_valid && (rsp_y == cap_y) && (rsp_id == cap_id) && (rsp_err == cap_err);
         rdy_seen |= req0_ready || req1_ready;
      end
      chk("stall stable", 64'(stable), 64'd1);
      chk("stall readys", 64'(rdy_seen), 64'd0);
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;

      // Reset in the middle of a MUL: dropped, then normal service resumes
      @(negedge clk);
      r_op[1] = 4'b0011; r_a[1] = 32'd6; r_b[1] = 32'd7; req_valid[1] = 1'b1;
      #1; waitc = 0;
      while (!req1_ready && waitc < 50) begin @(negedge clk); #1; waitc++; end
      chk("mulrst accept", 64'(req1_ready), 64'd1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      repeat (12) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mulrst rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mulrst alu", 64'({alu_a, alu_op}), 64'd0);
      chk("mulrst alu_b", 64'(alu_b), 64'd0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= rsp_valid; end
      chk("mulrst no rsp", 64'(seen), 64'd0);
      run_txn("post reset", 1, 4'b0011, 32'd6, 32'd7, 5'd0, 32'd42, 1'b0, 1'b0, W+1);

      // Random traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         int id;
         logic [3:0] op;
         logic [31:0] a, b;
         logic [4:0] sh;
         logic [31:0] sp [4];
         sp[0] = 32'h0; sp[1] = 32'hFFFFFFFF; sp[2] = 32'h80000000; sp[3] = 32'h7FFFFFFF;
         id = int'($urandom_range(0, 1));
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 3)] : $urandom;
         sh = 5'($urandom_range(0, 31));
         ref_model(op, a, b, sh, ey, eovf, eerr, elat);
         run_txn($sformatf("rnd%0d op%b", i, op), id, op, a, b, sh, ey, eovf, eerr, elat);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
